// File: rtl/unified_mem_arbiter.sv
// Round-robin arbiter sharing one single-port fixed-latency memory between
// instruction fetch and data access; one access in flight at a time.
module unified_mem_arbiter #(
    parameter int unsigned MEM_LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        if_done,
    output logic [15:0] if_rdata,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_done,
    output logic [15:0] d_rdata,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        busy
);

    localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic        r_last_d;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic        r_wr;
    logic        w_grant_i;
    logic        w_grant_d;
    logic        w_last;

    // Under contention the requester not served last time wins.
    always_comb begin
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        if (r_state == IDLE) begin
            w_grant_d = d_req && (!if_req || !r_last_d);
            w_grant_i = if_req && !w_grant_d;
        end
    end

    assign w_last = (r_state != IDLE) && (r_cnt == LAST_CNT);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_grant_d) begin
                    w_state_nxt = BUSY_D;
                end else if (w_grant_i) begin
                    w_state_nxt = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (w_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_last_d <= 1'b0;
            r_addr   <= '0;
            r_wr     <= 1'b0;
            r_wdata  <= '0;
        end else if (w_grant_d) begin
            r_cnt    <= '0;
            r_last_d <= 1'b1;
            r_addr   <= d_addr;
            r_wr     <= d_wr;
            r_wdata  <= d_wdata;
        end else if (w_grant_i) begin
            r_cnt    <= '0;
            r_last_d <= 1'b0;
            r_addr   <= if_addr;
            r_wr     <= 1'b0;
            r_wdata  <= '0;
        end else if (r_state != IDLE) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    // Memory side is driven only from the holding registers, never the inputs.
    always_comb begin
        busy      = 1'b0;
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if_done   = 1'b0;
        if_rdata  = '0;
        d_done    = 1'b0;
        d_rdata   = '0;
        if (r_state != IDLE) begin
            busy      = 1'b1;
            mem_en    = 1'b1;
            mem_wr    = r_wr;
            mem_addr  = r_addr;
            mem_wdata = r_wdata;
        end
        if (w_last && (r_state == BUSY_I)) begin
            if_done  = 1'b1;
            if_rdata = mem_rdata;
        end
        if (w_last && (r_state == BUSY_D)) begin
            d_done = 1'b1;
            if (!r_wr) begin
                d_rdata = mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: MEM_LAT=4 main instance plus a
// MEM_LAT=1 instance for back-to-back fetch timing.
module tb_unified_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        if_req = 1'b0;
    logic [15:0] if_addr = '0;
    logic        if_done;
    logic [15:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_wr = 1'b0;
    logic [15:0] d_addr = '0;
    logic [15:0] d_wdata = '0;
    logic        d_done;
    logic [15:0] d_rdata;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        busy;

    logic        if_req2 = 1'b0;
    logic [15:0] if_addr2 = '0;
    logic        if_done2;
    logic [15:0] if_rdata2;
    logic        d_done2;
    logic [15:0] d_rdata2;
    logic        mem_en2;
    logic        mem_wr2;
    logic [15:0] mem_addr2;
    logic [15:0] mem_wdata2;
    logic [15:0] mem_rdata2;
    logic        busy2;

    logic [15:0] mem [0:511];

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    // Memory model: word index = addr[9:1], preloaded with 16'h1000 + index.
    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 16'h1000 + 16'(i);
    end
    always @(posedge clk) begin
        if (mem_en && mem_wr) mem[mem_addr[9:1]] <= mem_wdata;
    end
    assign mem_rdata  = mem[mem_addr[9:1]];
    assign mem_rdata2 = mem[mem_addr2[9:1]];

    unified_mem_arbiter #(.MEM_LAT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    unified_mem_arbiter #(.MEM_LAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .if_req(if_req2), .if_addr(if_addr2), .if_done(if_done2), .if_rdata(if_rdata2),
        .d_req(1'b0), .d_wr(1'b0), .d_addr(16'h0000), .d_wdata(16'h0000),
        .d_done(d_done2), .d_rdata(d_rdata2),
        .mem_en(mem_en2), .mem_wr(mem_wr2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
        .mem_rdata(mem_rdata2), .busy(busy2)
    );

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        check_val("rst_busy", 16'(busy), 16'h0);
        check_val("rst_mem_en", 16'(mem_en), 16'h0);
        check_val("rst_mem_wr", 16'(mem_wr), 16'h0);
        check_val("rst_mem_addr", mem_addr, 16'h0000);
        check_val("rst_mem_wdata", mem_wdata, 16'h0000);
        check_val("rst_dones", {14'h0, if_done, d_done}, 16'h0);
        check_val("rst_rdata", if_rdata | d_rdata, 16'h0000);
        check_val("rst_busy2", 16'(busy2), 16'h0);
        do_reset();

        // Fetch only at 0x0010
        if_req = 1'b1; if_addr = 16'h0010;
        check_val("f_c0_busy", 16'(busy), 16'h0);
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 2) if_addr = 16'h1234;
            check_val("f_mem_en", 16'(mem_en), 16'h1);
            check_val("f_mem_wr", 16'(mem_wr), 16'h0);
            check_val("f_mem_addr", mem_addr, 16'h0010);
            check_val("f_if_done", 16'(if_done), (c == 4) ? 16'h1 : 16'h0);
            check_val("f_if_rdata", if_rdata, (c == 4) ? 16'h1008 : 16'h0000);
            check_val("f_d_done", 16'(d_done), 16'h0);
        end
        if_req = 1'b0;
        tick();
        check_val("f_c5_busy", 16'(busy), 16'h0);
        check_val("f_c5_mem_en", 16'(mem_en), 16'h0);
        check_val("f_c5_if_done", 16'(if_done), 16'h0);

        // Data write 0xBEEF to 0x0100
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0100; d_wdata = 16'hBEEF;
        for (int c = 1; c <= 4; c++) begin
            tick();
            check_val("w_mem_wr", 16'(mem_wr), 16'h1);
            check_val("w_mem_wdata", mem_wdata, 16'hBEEF);
            check_val("w_mem_addr", mem_addr, 16'h0100);
            check_val("w_d_done", 16'(d_done), (c == 4) ? 16'h1 : 16'h0);
            check_val("w_d_rdata", d_rdata, 16'h0000);
            check_val("w_if_done", 16'(if_done), 16'h0);
        end
        d_req = 1'b0;
        tick();
        check_val("w_c5_busy", 16'(busy), 16'h0);

        // Data read at 0x0200 with inputs changed mid-access
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0200; d_wdata = 16'h0000;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 2) begin
                d_addr = 16'hFFFE; d_wr = 1'b1; d_wdata = 16'h5555;
            end
            check_val("r_mem_addr", mem_addr, 16'h0200);
            check_val("r_mem_wr", 16'(mem_wr), 16'h0);
            check_val("r_d_done", 16'(d_done), (c == 4) ? 16'h1 : 16'h0);
            check_val("r_d_rdata", d_rdata, (c == 4) ? 16'h1100 : 16'h0000);
        end
        d_req = 1'b0;
        tick();

        // Read back the written word
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0100;
        for (int c = 1; c <= 4; c++) tick();
        check_val("rb_d_done", 16'(d_done), 16'h1);
        check_val("rb_d_rdata", d_rdata, 16'hBEEF);
        d_req = 1'b0;
        tick();

        // Both requests held from reset: data, fetch, data, fetch
        do_reset();
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0004;
        if_req = 1'b1; if_addr = 16'h0006;
        for (int c = 1; c <= 20; c++) begin
            int unsigned ph;
            logic        is_d;
            tick();
            ph   = (c - 1) % 5;
            is_d = (((c - 1) / 5) % 2) == 0;
            check_val("rr_busy", 16'(busy), (ph < 4) ? 16'h1 : 16'h0);
            check_val("rr_d_done", 16'(d_done), (ph == 3 && is_d) ? 16'h1 : 16'h0);
            check_val("rr_if_done", 16'(if_done), (ph == 3 && !is_d) ? 16'h1 : 16'h0);
            if (ph == 3) begin
                if (is_d) check_val("rr_d_rdata", d_rdata, 16'h1002);
                else      check_val("rr_if_rdata", if_rdata, 16'h1003);
            end
        end
        d_req = 1'b0; if_req = 1'b0;
        tick();

        // Reset in busy cycle 2 aborts, and data wins the next contention
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0200;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check_val("ab_mem_en", 16'(mem_en), 16'h0);
        check_val("ab_busy", 16'(busy), 16'h0);
        check_val("ab_d_done", 16'(d_done), 16'h0);
        #1;
        rst = 1'b0;
        if_req = 1'b1; if_addr = 16'h0010;
        for (int c = 1; c <= 9; c++) begin
            tick();
            check_val("ab_d_done2", 16'(d_done), (c == 4) ? 16'h1 : 16'h0);
            check_val("ab_if_done", 16'(if_done), (c == 9) ? 16'h1 : 16'h0);
            if (c == 4) begin
                check_val("ab_d_rdata", d_rdata, 16'h1100);
                d_req = 1'b0;
            end
            if (c == 9) begin
                check_val("ab_if_rdata", if_rdata, 16'h1008);
                if_req = 1'b0;
            end
        end
        tick();
        check_val("ab_idle", 16'(busy), 16'h0);

        // MEM_LAT=1 back-to-back fetches
        if_req2 = 1'b1; if_addr2 = 16'h0000;
        for (int k = 0; k < 4; k++) begin
            logic [15:0] exp_data;
            tick();
            case (k)
                0: exp_data = 16'h1000;
                1: exp_data = 16'h1001;
                2: exp_data = 16'h1008;
                default: exp_data = 16'hBEEF;
            endcase
            check_val("l1_if_done", 16'(if_done2), 16'h1);
            check_val("l1_if_rdata", if_rdata2, exp_data);
            check_val("l1_busy", 16'(busy2), 16'h1);
            case (k)
                0: if_addr2 = 16'h0002;
                1: if_addr2 = 16'h0010;
                2: if_addr2 = 16'h0100;
                default: if_req2 = 1'b0;
            endcase
            tick();
            check_val("l1_gap_done", 16'(if_done2), 16'h0);
            check_val("l1_gap_busy", 16'(busy2), 16'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
